// File: rtl/alu_div_pkg.sv
// Shared definitions for the iterative restoring divider beside the ALU.
// FSM state encoding and the default operand width.
package alu_div_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // 2'd3 is unused; the next-state logic sends it back to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/seq_div_restoring_if.sv
// Start/ready/done handshake and operand/result bus between the execute-stage
// controller (master) and the divider (slave).
interface seq_div_restoring_if
   import alu_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_div_restoring_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, and keep the difference only when it did not borrow.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   always_comb begin
      rem_sh = {rem[WIDTH-1:0], dvd_msb};
      trial  = rem_sh - {1'b0, divisor};
      // A set top bit in rem would place the shifted value above any divisor,
      // so the subtract always succeeds; in normal operation that bit stays 0.
      q_bit    = rem[WIDTH] | ~trial[WIDTH];
      rem_next = q_bit ? trial : rem_sh;
   end

endmodule

// File: rtl/seq_div_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results
// held stable from the done pulse until the next accepted start.
module seq_div_restoring
   import alu_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_div_restoring_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e           state;
   state_e           state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dz_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .dvd_msb  (dvd[WIDTH-1]),
      .divisor  (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start) state_next = (bus.divisor != '0) ? RUN : DONE;
         RUN:  if (cnt == '0) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: reset is sampled on the clock edge and clears the datapath too, so
   // an aborted division leaves no stale operands or results behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading the
         // pre-edge values, independent of statement order.
         state  <= state_next;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dvd <= bus.dividend;
                  dvs <= bus.divisor;
                  rem <= '0;
                  cnt <= CNT_W'(WIDTH - 1);
               end
            end
            RUN: begin
               // Quotient bits fill the dividend register as it empties
               dvd <= {dvd[WIDTH-2:0], q_bit};
               rem <= rem_next;
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            DONE: begin
               done_q <= 1'b1;
               if (dvs == '0) begin
                  quotient_q  <= '1;
                  remainder_q <= dvd;
                  dz_q        <= 1'b1;
               end else begin
                  quotient_q  <= dvd;
                  remainder_q <= rem[WIDTH-1:0];
                  dz_q        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready       = (state == IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_div_restoring.sv
// Scoreboard bench for seq_div_restoring at WIDTH=8 (directed + random) and
// WIDTH=16 (random); monitors pop expected results on every done pulse.
module tb_seq_div_restoring;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          acc;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb8[$];
   exp_t sb16[$];

   seq_div_restoring_if #(.WIDTH(8))  b8  ();
   seq_div_restoring_if #(.WIDTH(16)) b16 ();

   seq_div_restoring #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8.slave)
   );

   seq_div_restoring #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b16.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitors: a done pulse must match the oldest outstanding request,
   // arriving after edge acc+lat (acc = accept edge number).
   always @(negedge clk) begin
      if (b8.done === 1'b1) begin
         if (sb8.size() == 0) fail_now("w8 unexpected done");
         else begin
            exp_t e;
            e = sb8.pop_front();
            check("w8 quotient", 32'(b8.quotient), 32'(e.q));
            check("w8 remainder", 32'(b8.remainder), 32'(e.r));
            check("w8 div_by_zero", 32'(b8.div_by_zero), 32'(e.dz));
            check("w8 latency", cyc - e.acc, e.lat);
         end
      end
   end

   always @(negedge clk) begin
      if (b16.done === 1'b1) begin
         if (sb16.size() == 0) fail_now("w16 unexpected done");
         else begin
            exp_t e;
            e = sb16.pop_front();
            check("w16 quotient", 32'(b16.quotient), 32'(e.q));
            check("w16 remainder", 32'(b16.remainder), 32'(e.r));
            check("w16 div_by_zero", 32'(b16.div_by_zero), 32'(e.dz));
            check("w16 latency", cyc - e.acc, e.lat);
         end
      end
   end

   // Called at a negedge. Done comes after edge acc+WIDTH+1 (acc+1 for /0).
   // With noisy set, start and operands are jabbed while the divider is busy.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic edz, input bit noisy);
      bit seen = 0;
      for (int i = 0; i < 40 && b8.ready !== 1'b1; i++) @(negedge clk);
      b8.start    = 1'b1;
      b8.dividend = a;
      b8.divisor  = b;
      @(posedge clk);
      #1;
      sb8.push_back('{q: 16'(eq), r: 16'(er), dz: edz, acc: cyc, lat: edz ? 1 : 9});
      b8.start    = 1'b0;
      b8.dividend = 8'($urandom);
      b8.divisor  = 8'($urandom);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (b8.done === 1'b1) begin
            seen     = 1;
            b8.start = 1'b0;
            check("w8 ready in done cycle", 32'(b8.ready), 32'd1);
         end else begin
            check("w8 ready while busy", 32'(b8.ready), 32'd0);
            if (noisy) begin
               b8.start    = 1'b1;
               b8.dividend = 8'($urandom);
               b8.divisor  = 8'($urandom);
            end
         end
      end
      if (!seen) fail_now("w8 done timeout");
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                       input logic [15:0] er, input logic edz, input bit noisy);
      bit seen = 0;
      for (int i = 0; i < 60 && b16.ready !== 1'b1; i++) @(negedge clk);
      b16.start    = 1'b1;
      b16.dividend = a;
      b16.divisor  = b;
      @(posedge clk);
      #1;
      sb16.push_back('{q: eq, r: er, dz: edz, acc: cyc, lat: edz ? 1 : 17});
      b16.start    = 1'b0;
      b16.dividend = 16'($urandom);
      b16.divisor  = 16'($urandom);
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (b16.done === 1'b1) begin
            seen      = 1;
            b16.start = 1'b0;
            check("w16 ready in done cycle", 32'(b16.ready), 32'd1);
         end else begin
            check("w16 ready while busy", 32'(b16.ready), 32'd0);
            if (noisy) begin
               b16.start    = 1'b1;
               b16.dividend = 16'($urandom);
               b16.divisor  = 16'($urandom);
            end
         end
      end
      if (!seen) fail_now("w16 done timeout");
   endtask

   task automatic rand8(input int n);
      logic [7:0] a;
      logic [7:0] b;
      for (int k = 0; k < n; k++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 99) < 5) ? 8'd0 : 8'($urandom);
         repeat ($urandom_range(0, 3)) begin
            b8.dividend = 8'($urandom);
            b8.divisor  = 8'($urandom);
            @(negedge clk);
         end
         if (b == 8'd0) op8(a, b, 8'hFF, a, 1'b1, 1'($urandom_range(0, 1)));
         else           op8(a, b, a / b, a % b, 1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic rand16(input int n);
      logic [15:0] a;
      logic [15:0] b;
      for (int k = 0; k < n; k++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 99) < 5) ? 16'd0 : 16'($urandom);
         repeat ($urandom_range(0, 3)) begin
            b16.dividend = 16'($urandom);
            b16.divisor  = 16'($urandom);
            @(negedge clk);
         end
         if (b == 16'd0) op16(a, b, 16'hFFFF, a, 1'b1, 1'($urandom_range(0, 1)));
         else            op16(a, b, a / b, a % b, 1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      b8.start     = 1'b0;
      b8.dividend  = '0;
      b8.divisor   = '0;
      b16.start    = 1'b0;
      b16.dividend = '0;
      b16.divisor  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      check("reset ready", 32'(b8.ready), 32'd1);
      check("reset done", 32'(b8.done), 32'd0);
      check("reset quotient", 32'(b8.quotient), 32'd0);
      check("reset remainder", 32'(b8.remainder), 32'd0);
      check("reset div_by_zero", 32'(b8.div_by_zero), 32'd0);

      // Directed vectors with hand-computed results
      op8(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0);
      op8(8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1'b0);
      op8(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 1'b0);
      op8(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0);
      op8(8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 1'b0);
      op8(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0);
      op8(8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 1'b0);
      op8(8'd200, 8'd13,  8'd15,  8'd5,   1'b0, 1'b1);
      repeat (12) @(negedge clk);

      // Abort 77/4 with reset at RUN cycle 4; no done may follow
      b8.start    = 1'b1;
      b8.dividend = 8'd77;
      b8.divisor  = 8'd4;
      @(posedge clk);
      #1;
      b8.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort ready", 32'(b8.ready), 32'd1);
      check("abort done", 32'(b8.done), 32'd0);
      check("abort quotient", 32'(b8.quotient), 32'd0);
      check("abort remainder", 32'(b8.remainder), 32'd0);
      check("abort div_by_zero", 32'(b8.div_by_zero), 32'd0);
      repeat (12) @(negedge clk);
      op8(8'd77, 8'd4, 8'd19, 8'd1, 1'b0, 1'b0);

      fork
         rand8(2000);
         rand16(2000);
      join

      repeat (25) @(negedge clk);
      check("w8 scoreboard drained", 32'(sb8.size()), 32'd0);
      check("w16 scoreboard drained", 32'(sb16.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
